// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSN_W = 32;

    localparam logic [INSN_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0080;
    localparam logic [INSN_W-1:0] HALT_INSN_DEFAULT = 32'h0010_0073;
    localparam logic [INSN_W-1:0] PC_STEP           = 32'h0000_0004;
    localparam logic [INSN_W-1:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // IF/ID boundary payload
    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [INSN_W-1:0] pc;
        logic [INSN_W-1:0] pcp4;
    } if_id_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: redirect > stall > accepted fetch > hold; also decides imem_req.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [INSN_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              redirect_en,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic              redirect_valid,
    input  logic [INSN_W-1:0] redirect_pc,
    output logic [INSN_W-1:0] next_pc_c,
    output logic              req_c,
    output logic              accept_c,
    output logic              redirect_c
);

    always_comb begin
        req_c      = fetch_en && !stall && !redirect_valid;
        accept_c   = req_c && imem_ready;
        redirect_c = redirect_en && redirect_valid;
        next_pc_c  = pc;
        if (redirect_c) begin
            next_pc_c = redirect_pc & PC_ALIGN_MASK;
        end else if (accept_c) begin
            next_pc_c = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests, fills IF/ID, stops on HALT_INSN.
// Optional macro FETCH_COUNT_EN adds the fetch_count output (accepted-fetch counter).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [INSN_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSN_W-1:0] HALT_INSN = HALT_INSN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [INSN_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [INSN_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [INSN_W-1:0] id_insn,
    output logic [INSN_W-1:0] id_pc,
    output logic [INSN_W-1:0] id_pcp4,
    output logic              halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [INSN_W-1:0] fetch_count
`endif
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [INSN_W-1:0] pc_q;
    if_id_t            id_q;
    logic              id_valid_q;
    logic              halted_q;

    logic [INSN_W-1:0] next_pc_c;
    logic              req_c;
    logic              accept_c;
    logic              redirect_c;
    logic              halt_hit_c;
    logic              id_load_c;
    logic              id_clear_c;

    next_pc_sel u_next_pc_sel (
        .pc             (pc_q),
        .fetch_en       (state_q == REQ),
        .redirect_en    (state_q != HALT),
        .stall          (stall),
        .imem_ready     (imem_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc_c      (next_pc_c),
        .req_c          (req_c),
        .accept_c       (accept_c),
        .redirect_c     (redirect_c)
    );

    assign halt_hit_c = accept_c && (imem_rdata == HALT_INSN);

    // Next state and IF/ID load/clear decisions
    always_comb begin
        state_d    = state_q;
        id_load_c  = 1'b0;
        id_clear_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d    = REQ;
                id_clear_c = 1'b1;
            end
            REQ: begin
                if (redirect_c) begin
                    id_clear_c = 1'b1;
                end else if (accept_c) begin
                    id_load_c = 1'b1;
                    if (halt_hit_c) begin
                        state_d = HALT;
                    end
                end else if (!stall) begin
                    id_clear_c = 1'b1;
                end
            end
            HALT: begin
                id_clear_c = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= next_pc_c;
            halted_q <= (state_d == HALT);
        end
    end

    // IF/ID boundary register; a stall in REQ holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q       <= '0;
            id_valid_q <= 1'b0;
        end else if (id_load_c) begin
            id_q.insn  <= imem_rdata;
            id_q.pc    <= pc_q;
            id_q.pcp4  <= pc_q + PC_STEP;
            id_valid_q <= 1'b1;
        end else if (id_clear_c) begin
            id_valid_q <= 1'b0;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [INSN_W-1:0] fetch_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else if (accept_c) begin
            fetch_count_q <= fetch_count_q + INSN_W'(1);
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign imem_req  = req_c;
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_insn   = id_q.insn;
    assign id_pc     = id_q.pc;
    assign id_pcp4   = id_q.pcp4;
    assign halted    = halted_q;

endmodule
